// File: rtl/zion_basic_circuit_lib_pkg.sv
// Shared types for the basic circuit library's valid/ready handshake slices.
package zion_basic_circuit_lib_pkg;

    // Occupancy of a two-entry register slice.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } skid_state_e;

endpackage

// Instantiates a clearable skid buffer with widths taken from the connected data signals.
`ifndef ZION_BASIC_CIRCUIT_LIB_CLR_SKID_BUF
`define ZION_BASIC_CIRCUIT_LIB_CLR_SKID_BUF(uname, clk_, rst_, clr_, ivld_, ordy_, idat_, ovld_, irdy_, odat_, ini_) \
    zion_basic_circuit_lib_clr_skid_buf #( \
        .WIDTH_IN  ($bits(idat_)), \
        .WIDTH_OUT ($bits(odat_)), \
        .INI_DATA  (ini_) \
    ) uname ( \
        .clk  (clk_), \
        .rst  (rst_), \
        .iClr (clr_), \
        .iVld (ivld_), \
        .oRdy (ordy_), \
        .iDat (idat_), \
        .oVld (ovld_), \
        .iRdy (irdy_), \
        .oDat (odat_) \
    );
`endif

// File: rtl/zion_basic_circuit_lib_clr_skid_buf.sv
// Two-entry valid/ready register slice with synchronous clear. Both the forward
// (valid/data) and backward (ready) paths come straight from registers.
module zion_basic_circuit_lib_clr_skid_buf
    import zion_basic_circuit_lib_pkg::*;
#(
    parameter int unsigned          WIDTH_IN  = 8,
    parameter int unsigned          WIDTH_OUT = 8,
    parameter logic [WIDTH_OUT-1:0] INI_DATA  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iClr,
    input  logic                 iVld,
    output logic                 oRdy,
    input  logic [WIDTH_IN-1:0]  iDat,
    output logic                 oVld,
    input  logic                 iRdy,
    output logic [WIDTH_OUT-1:0] oDat
);

    if (WIDTH_IN != WIDTH_OUT) begin : g_width_check
`ifdef CHECK_ERR_EXIT
        $fatal(1, "zion_basic_circuit_lib_clr_skid_buf: WIDTH_IN (%0d) != WIDTH_OUT (%0d)",
               WIDTH_IN, WIDTH_OUT);
`else
        $error("zion_basic_circuit_lib_clr_skid_buf: WIDTH_IN (%0d) != WIDTH_OUT (%0d)",
               WIDTH_IN, WIDTH_OUT);
`endif
    end

    skid_state_e         state_q, state_d;
    logic [WIDTH_IN-1:0] main_q, main_d;
    logic [WIDTH_IN-1:0] skid_q, skid_d;
    logic                accept;
    logic                xfer;

    // Handshake flags decode only the state register, so no input reaches them combinationally.
    always_comb begin
        oVld = (state_q != StEmpty);
        oRdy = (state_q != StFull);
        oDat = main_q;
    end

    // Next-state and data-path selection; clear overrides any handshake in the same cycle.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        accept  = iVld && oRdy;
        xfer    = oVld && iRdy;

        if (iClr) begin
            state_d = StEmpty;
            main_d  = INI_DATA;
            skid_d  = INI_DATA;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d = StOne;
                        main_d  = iDat;
                    end
                end
                StOne: begin
                    if (accept && xfer) begin
                        main_d = iDat;
                    end else if (accept) begin
                        state_d = StFull;
                        skid_d  = iDat;
                    end else if (xfer) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    // oRdy is low here, so only the drain side can move.
                    if (xfer) begin
                        state_d = StOne;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = StEmpty;
                end
            endcase
        end
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            main_q  <= INI_DATA;
            skid_q  <= INI_DATA;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule
